// File: rtl/acc_sched_pkg.sv
// Shared types and the accumulate helper for acc_rr_scheduler.
// ACC_SAT_EN: when defined, out-of-range sums clamp instead of wrapping.
package acc_sched_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int ACC_W_DEF = 8;
  localparam int UPD_W_DEF = 4;
  localparam int CALC_W    = 32;

  typedef logic signed [ACC_W_DEF-1:0]         acc_t;
  typedef logic signed [UPD_W_DEF-1:0]         upd_t;
  typedef logic [$clog2(N_REQ_DEF)-1:0]        idx_t;
  typedef logic signed [CALC_W-1:0]            calc_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef struct packed {
    calc_t sum;
    logic  ovf;
    logic  unf;
  } add_res_t;

  // Operands arrive sign-extended; bits [w:w-1] of the sum act as the
  // (w+1)-bit adder's extra carry and MSB.
  function automatic add_res_t acc_add(input calc_t acc, input calc_t upd, input int w);
    add_res_t r;
    r.sum = acc + upd;
    r.ovf = ~r.sum[w] & r.sum[w-1];
    r.unf = r.sum[w] & ~r.sum[w-1];
`ifdef ACC_SAT_EN
    if (r.ovf)      r.sum = (calc_t'(1) <<< (w-1)) - calc_t'(1);
    else if (r.unf) r.sum = -(calc_t'(1) <<< (w-1));
`endif
    return r;
  endfunction
endpackage

// File: rtl/acc_rr_scheduler_rr_arb.sv
// Round-robin arbiter: priority starts just after the last granted index.
module rr_arb #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  input  logic                     hs_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);
  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] last_q, last_d;
  logic          found;
  int            j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last_q) + k) % N_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    last_d = hs_i ? idx_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IW'(N_REQ-1);
    else     last_q <= last_d;
  end
endmodule

// File: rtl/acc_rr_scheduler.sv
// N_REQ private signed accumulators sharing one adder via round-robin grant.
// ACC_SAT_EN (see acc_sched_pkg) selects saturating instead of wrapping results.
module acc_rr_scheduler
  import acc_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ACC_W = 8,
  parameter int UPD_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ-1:0]         req_clr_i,
  input  logic [N_REQ*UPD_W-1:0]   req_upd_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [$clog2(N_REQ)-1:0] res_idx_o,
  output logic [ACC_W-1:0]         res_acc_o,
  output logic                     res_ovf_o,
  output logic                     res_unf_o,
  output logic [N_REQ-1:0]         sticky_ovf_o,
  output logic [N_REQ-1:0]         sticky_unf_o,
  input  logic [N_REQ-1:0]         flag_clr_i
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0][ACC_W-1:0] acc_q, acc_d;
  logic                        res_valid_q, res_valid_d;
  logic [IW-1:0]               res_idx_q, res_idx_d;
  logic [ACC_W-1:0]            res_acc_q, res_acc_d;
  logic                        res_ovf_q, res_ovf_d, res_unf_q, res_unf_d;
  logic [N_REQ-1:0]            sticky_ovf_q, sticky_ovf_d, sticky_unf_q, sticky_unf_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             stall, hs, op_clr, op_ovf, op_unf;
  logic [ACC_W-1:0] sel_acc, op_acc;
  logic [UPD_W-1:0] sel_upd;
  add_res_t         add_r;
  logic             unused_sum;

  rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_valid_i),
    .hs_i  (hs),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // A held result blocks new grants so the result registers never get overwritten.
  assign stall       = res_valid_q & ~res_ready_i;
  assign req_ready_o = (rst | stall) ? '0 : gnt;
  assign hs          = |(req_valid_i & req_ready_o);

  assign sel_acc = acc_q[gnt_idx];
  assign sel_upd = req_upd_i[int'(gnt_idx)*UPD_W +: UPD_W];
  assign add_r   = acc_add({{(CALC_W-ACC_W){sel_acc[ACC_W-1]}}, sel_acc},
                           {{(CALC_W-UPD_W){sel_upd[UPD_W-1]}}, sel_upd}, ACC_W);
  assign unused_sum = ^add_r.sum[CALC_W-1:ACC_W];

  assign op_clr = req_clr_i[gnt_idx];
  assign op_acc = op_clr ? '0 : add_r.sum[ACC_W-1:0];
  assign op_ovf = ~op_clr & add_r.ovf;
  assign op_unf = ~op_clr & add_r.unf;

  always_comb begin
    acc_d        = acc_q;
    res_valid_d  = res_valid_q;
    res_idx_d    = res_idx_q;
    res_acc_d    = res_acc_q;
    res_ovf_d    = res_ovf_q;
    res_unf_d    = res_unf_q;
    sticky_ovf_d = sticky_ovf_q & ~flag_clr_i;
    sticky_unf_d = sticky_unf_q & ~flag_clr_i;
    if (hs) begin
      acc_d[gnt_idx]        = op_acc;
      res_valid_d           = 1'b1;
      res_idx_d             = gnt_idx;
      res_acc_d             = op_acc;
      res_ovf_d             = op_ovf;
      res_unf_d             = op_unf;
      sticky_ovf_d[gnt_idx] = sticky_ovf_d[gnt_idx] | op_ovf;
      sticky_unf_d[gnt_idx] = sticky_unf_d[gnt_idx] | op_unf;
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      res_valid_q  <= 1'b0;
      res_idx_q    <= '0;
      res_acc_q    <= '0;
      res_ovf_q    <= 1'b0;
      res_unf_q    <= 1'b0;
      sticky_ovf_q <= '0;
      sticky_unf_q <= '0;
    end else begin
      acc_q        <= acc_d;
      res_valid_q  <= res_valid_d;
      res_idx_q    <= res_idx_d;
      res_acc_q    <= res_acc_d;
      res_ovf_q    <= res_ovf_d;
      res_unf_q    <= res_unf_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_idx_o    = res_idx_q;
  assign res_acc_o    = res_acc_q;
  assign res_ovf_o    = res_ovf_q;
  assign res_unf_o    = res_unf_q;
  assign sticky_ovf_o = sticky_ovf_q;
  assign sticky_unf_o = sticky_unf_q;
endmodule
